// File: rtl/pes_bcdbin_n.sv
// pes_bcdbin_n
// Packed-BCD to binary converter built on serial reverse double-dabble.
// Each OP cycle shifts the digit vector right by one bit. The bit that falls
// out of digit 0 enters the result MSB. Any nibble that ends up >= 8 then
// has 3 subtracted from it. After BW cycles the result holds the value.
// An operand with a nibble above 9 skips the shifting: err is set and the
// block goes straight to DONE.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      conversion request, taken only while o_ready=1
//   i_bcd        packed BCD operand, i_bcd[3:0] is the least-significant digit
//   o_bin        binary result, final from the o_done_tick cycle on
//   o_ready      high in IDLE only
//   o_done_tick  one-cycle pulse in DONE
//   o_err        last accepted operand contained a nibble > 9
//
// state  | meaning
// S_IDLE | waiting for i_start, operand captured on acceptance
// S_OP   | one shift/correct step per cycle, BW steps in total
// S_DONE | result valid, o_done_tick pulse, back to IDLE next cycle
module pes_bcdbin_n #(
  parameter int NDIG = 4,
  parameter int BW   = 14
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [4*NDIG-1:0] i_bcd,
  output logic [BW-1:0]     o_bin,
  output logic              o_ready,
  output logic              o_done_tick,
  output logic              o_err
);

  localparam int DW = 4 * NDIG;
  localparam int CW = $clog2(BW + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_digits;
  logic [BW-1:0]   r_bin;
  logic [CW-1:0]   r_cnt;
  logic            r_err;

  logic [DW-1:0]   w_shift;
  logic [DW-1:0]   w_adj;
  logic [NDIG-1:0] w_nib_bad;
  logic            w_bad;

  assign w_shift = r_digits >> 1;

  for (genvar g = 0; g < NDIG; g++) begin : g_nib
    // After the shift, bit 3 of a nibble set means the LSB of the digit above
    // came in, worth 10/2 = 5 here. That shows up as 8, so take 3 off.
    assign w_adj[4*g +: 4] = w_shift[4*g+3] ? (w_shift[4*g +: 4] - 4'd3)
                                            : w_shift[4*g +: 4];
    // A nibble above 9 is 1010..1111: bit 3 set together with bit 2 or bit 1.
    assign w_nib_bad[g] = i_bcd[4*g+3] & (i_bcd[4*g+2] | i_bcd[4*g+1]);
  end

  assign w_bad = |w_nib_bad;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_digits <= '0;
      r_bin    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_digits <= i_bcd;
            r_bin    <= '0;
            r_err    <= w_bad;
            if (w_bad) begin
              r_state <= S_DONE;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_OP;
            end
          end
        end
        S_OP: begin
          r_bin    <= {r_digits[0], r_bin[BW-1:1]};
          r_digits <= w_adj;
          r_cnt    <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_bin       = r_bin;
  assign o_err       = r_err;
  assign o_ready     = (r_state == S_IDLE);
  assign o_done_tick = (r_state == S_DONE);

endmodule

// File: tb/tb_pes_bcdbin_n.sv
module tb_pes_bcdbin_n;

  localparam int BW1 = 14;
  localparam int BW2 = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic [15:0] bcd1;
  logic [7:0]  bcd2;
  logic [13:0] bin1;
  logic [6:0]  bin2;
  logic        ready1, ready2, done1, done2, err1, err2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int bin;
    bit err;
    int due;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  exp_t cur1, cur2, hold1, hold2;
  bit   hold1_v = 1'b0;
  bit   hold2_v = 1'b0;

  pes_bcdbin_n #(.NDIG(4), .BW(BW1)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_bcd(bcd1),
    .o_bin(bin1), .o_ready(ready1), .o_done_tick(done1), .o_err(err1)
  );

  pes_bcdbin_n #(.NDIG(2), .BW(BW2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_bcd(bcd2),
    .o_bin(bin2), .o_ready(ready2), .o_done_tick(done2), .o_err(err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Decimal value of the operand, digit by digit; any digit above 9 marks
  // the operand invalid and the expected result is then 0.
  function automatic void ref_model(input logic [15:0] bcd, input int nd,
                                    output int val, output bit err);
    int d;
    val = 0;
    err = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'((bcd >> (4 * i)) & 16'hF);
      if (d > 9) err = 1'b1;
      val = val * 10 + d;
    end
    if (err) val = 0;
  endfunction

  // Monitors: pop an expectation on each done pulse, then confirm the result
  // is still held in the following IDLE cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (done1) begin
        if (sb1.size() == 0) begin
          chk("d4_unexpected_done", 1, 0);
        end else begin
          cur1 = sb1.pop_front();
          chk("d4_bin", 32'(bin1), cur1.bin);
          chk("d4_err", 32'(err1), 32'(cur1.err));
          chk("d4_done_cycle", cyc, cur1.due);
          chk("d4_ready_in_done", 32'(ready1), 0);
          hold1   = cur1;
          hold1_v = 1'b1;
        end
      end else if (hold1_v) begin
        chk("d4_hold_bin", 32'(bin1), hold1.bin);
        chk("d4_hold_err", 32'(err1), 32'(hold1.err));
        chk("d4_ready_after_done", 32'(ready1), 1);
        hold1_v = 1'b0;
      end
      if (done2) begin
        if (sb2.size() == 0) begin
          chk("d2_unexpected_done", 1, 0);
        end else begin
          cur2 = sb2.pop_front();
          chk("d2_bin", 32'(bin2), cur2.bin);
          chk("d2_err", 32'(err2), 32'(cur2.err));
          chk("d2_done_cycle", cyc, cur2.due);
          hold2   = cur2;
          hold2_v = 1'b1;
        end
      end else if (hold2_v) begin
        chk("d2_hold_bin", 32'(bin2), hold2.bin);
        chk("d2_ready_after_done", 32'(ready2), 1);
        hold2_v = 1'b0;
      end
    end else begin
      hold1_v = 1'b0;
      hold2_v = 1'b0;
    end
  end

  // Issue one conversion on the 4-digit DUT. Returns 1 time unit after the
  // accepting edge; with hold=1 the start line is left high.
  task automatic drive1(input logic [15:0] v, input bit hold);
    int   k, val;
    bit   e;
    exp_t x;
    k = 0;
    @(negedge clk);
    while (!ready1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!ready1) chk("d4_ready_timeout", 0, 1);
    bcd1   = v;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    ref_model(v, 4, val, e);
    x.bin = val;
    x.err = e;
    x.due = cyc + (e ? 0 : BW1);
    sb1.push_back(x);
    if (!hold) start1 = 1'b0;
  endtask

  task automatic drive2(input logic [7:0] v);
    int   k, val;
    bit   e;
    exp_t x;
    k = 0;
    @(negedge clk);
    while (!ready2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!ready2) chk("d2_ready_timeout", 0, 1);
    bcd2   = v;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    ref_model({8'h00, v}, 2, val, e);
    x.bin = val;
    x.err = e;
    x.due = cyc + (e ? 0 : BW2);
    sb2.push_back(x);
    start2 = 1'b0;
  endtask

  initial begin : main
    int          t1, val, k;
    bit          e;
    exp_t        x;
    logic [15:0] v;
    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    bcd1   = '0;
    bcd2   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bin", 32'(bin1), 0);
    chk("rst_err", 32'(err1), 0);
    chk("rst_ready", 32'(ready1), 1);
    chk("rst_done", 32'(done1), 0);
    chk("rst2_ready", 32'(ready2), 1);
    chk("rst2_bin", 32'(bin2), 0);

    // directed operands, including invalid digits and error recovery
    drive1(16'h9999, 1'b0);
    drive1(16'h0000, 1'b0);
    drive1(16'h1234, 1'b0);
    drive1(16'h12A4, 1'b0);
    drive1(16'h0042, 1'b0);
    drive1(16'hF000, 1'b0);
    drive1(16'h8080, 1'b0);

    // start pulsed during OP with another operand must be ignored
    drive1(16'h1234, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bcd1   = 16'h5678;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("op_ready_low", 32'(ready1), 0);

    // start held high: back-to-back, operand changes after acceptance are ignored
    drive1(16'h0777, 1'b1);
    t1   = cyc;
    bcd1 = 16'h0321;
    ref_model(16'h0321, 4, val, e);
    x.bin = val;
    x.err = e;
    x.due = t1 + 16 + BW1;
    sb1.push_back(x);
    repeat (16) @(posedge clk);
    #1;
    chk("b2b_accepted", 32'(ready1), 0);
    bcd1 = 16'h9876;
    @(negedge clk);
    start1 = 1'b0;

    // reset in the middle of a conversion abandons it
    drive1(16'h4321, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb1.delete();
    chk("midrst_bin", 32'(bin1), 0);
    chk("midrst_ready", 32'(ready1), 1);
    chk("midrst_done", 32'(done1), 0);
    chk("midrst_err", 32'(err1), 0);
    repeat (20) @(negedge clk);

    // random operands, about one in six carrying a bad nibble
    for (int n = 0; n < 150; n++) begin
      v = '0;
      for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) begin
        k = int'($urandom_range(0, 3));
        v[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      drive1(v, 1'b0);
    end

    // 2-digit instance: directed, invalid, then the full valid sweep
    drive2(8'h99);
    drive2(8'hA5);
    drive2(8'h3F);
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++)
        drive2({4'(a), 4'(b)});

    k = 0;
    while ((sb1.size() != 0 || sb2.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_sb4", sb1.size(), 0);
    chk("drain_sb2", sb2.size(), 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
